sq_integral_generator: RTL and testbench

- Upstream producer for the squared-integral-image cache (`pkg_SQImageCache`).
- Accepts a raster-order pixel stream and squares each pixel. Computes the squared integral image II(x+1,y+1) = Σ p² over all pixels at or above-left of (x,y).
- Emits one cache write per result through the cache's write-interface signal set.
- Also writes the zero border (row 0, column 0) of the (W+1)×(H+1) cache each frame, so the cache is self-consistent with no external clearing.

---
 rtl/sq_integral_generator_pkg.sv | 25 ++
 rtl/sq_integral_generator_line_buffer.sv | 35 +++
 rtl/sq_integral_generator.sv | 218 +++++++++++++++++++++
 tb/tb_sq_integral_generator.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_integral_generator_pkg.sv
// Shared types and sizes for the squared-integral-image cache.
// Imported by the generator and its line buffer.
package pkg_SQImageCache;

  localparam int supportedImageWidth  = 4;
  localparam int supportedImageHeight = 3;
  localparam int inputImageDepth      = 8;

  localparam int WORD_SIZE = 32;
  localparam int ROW_WIDTH = 3;
  localparam int COL_WIDTH = 2;

  localparam int SQ_PIPE_LAT = 2;

  typedef logic [WORD_SIZE-1:0] sq_word_t;

  typedef enum logic [2:0] {
    IDLE,
    CLR_ROW,
    CLR_COL,
    PIXELS,
    DRAIN
  } sq_state_t;

endpackage

// File: rtl/sq_integral_generator_line_buffer.sv
// One-row store of previous-row integral values.
// Registered read; a same-cycle write to the read index is forwarded.
module sq_line_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // write port: storage is never cleared, the first row ignores it
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // read port with write-first bypass
  always_ff @(posedge clk) begin
    if (i_re) begin
      if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
      else r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sq_integral_generator.sv
// Squared integral image producer: border clear, then a
// two-stage pipeline writing II(x+1,y+1) into the cache.
module sq_integral_generator
  import pkg_SQImageCache::*;
#(
  parameter int IMG_WIDTH  = pkg_SQImageCache::supportedImageWidth,
  parameter int IMG_HEIGHT = pkg_SQImageCache::supportedImageHeight,
  parameter int PIX_BITS   = pkg_SQImageCache::inputImageDepth,
  parameter int WORD_SIZE  = pkg_SQImageCache::WORD_SIZE,
  parameter int ROW_WIDTH  = pkg_SQImageCache::ROW_WIDTH,
  parameter int COL_WIDTH  = pkg_SQImageCache::COL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PIX_BITS-1:0]  pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [ROW_WIDTH-1:0] waddrX,
  output logic [COL_WIDTH-1:0] waddrY,
  output logic [WORD_SIZE-1:0] wdata,
  output logic                 we,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CW =
    (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH;
  localparam int LB_AW =
    (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_HEIGHT);
  localparam logic [ROW_WIDTH-1:0] X_LAST =
    ROW_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] Y_LAST =
    COL_WIDTH'(IMG_HEIGHT - 1);

  sq_state_t r_state, w_next;

  logic [CW-1:0]        r_cnt;
  logic [ROW_WIDTH-1:0] r_px;
  logic [COL_WIDTH-1:0] r_py;

  logic w_accept, w_last_pix, w_clr_we, w_drained;

  logic [2*PIX_BITS-1:0] w_sq;
  logic [WORD_SIZE-1:0]  w_lb_rd, w_rowsum, w_wdata;
  logic [WORD_SIZE-1:0]  r_rowsum;

  logic                 r_s1_v, r_s1_fr, r_s1_fc;
  logic [WORD_SIZE-1:0] r_s1_sq;
  logic [ROW_WIDTH-1:0] r_s1_x;
  logic [COL_WIDTH-1:0] r_s1_y;

  logic                 r_s2_v, r_s2_fr, r_s2_fc;
  logic [WORD_SIZE-1:0] r_s2_sq;
  logic [ROW_WIDTH-1:0] r_s2_x;
  logic [COL_WIDTH-1:0] r_s2_y;

  assign w_accept   = pix_valid && (r_state == PIXELS);
  assign w_last_pix = (r_px == X_LAST) && (r_py == Y_LAST);
  assign w_drained  = !r_s1_v && !r_s2_v;
  assign w_sq = {{PIX_BITS{1'b0}}, pix_in}
              * {{PIX_BITS{1'b0}}, pix_in};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next state and control outputs
  always_comb begin
    w_next     = r_state;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    w_clr_we   = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = CLR_ROW;
      end
      CLR_ROW: begin
        w_clr_we = 1'b1;
        if (r_cnt == ROW_LAST) w_next = CLR_COL;
      end
      CLR_COL: begin
        w_clr_we = 1'b1;
        if (r_cnt == COL_LAST) w_next = PIXELS;
      end
      PIXELS: begin
        pix_ready = 1'b1;
        if (w_accept && w_last_pix) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_drained) begin
          frame_done = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // border clear counter: x = 0..W, then y = 1..H
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else begin
      unique case (r_state)
        CLR_ROW:
          r_cnt <= (r_cnt == ROW_LAST) ? CW'(1) : r_cnt + CW'(1);
        CLR_COL: r_cnt <= r_cnt + CW'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  // raster coordinates, advancing only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px <= '0;
      r_py <= '0;
    end else if (r_state != PIXELS) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_accept) begin
      if (r_px == X_LAST) begin
        r_px <= '0;
        r_py <= r_py + COL_WIDTH'(1);
      end else begin
        r_px <= r_px + ROW_WIDTH'(1);
      end
    end
  end

  // stage 1: square and position flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_s1_sq <= '0;
      r_s1_x  <= '0;
      r_s1_y  <= '0;
      r_s1_fr <= 1'b0;
      r_s1_fc <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_sq <= WORD_SIZE'(w_sq);
        r_s1_x  <= r_px;
        r_s1_y  <= r_py;
        r_s1_fr <= (r_py == '0);
        r_s1_fc <= (r_px == '0);
      end
    end
  end

  // stage 2 payload, aligned with the line-buffer read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_s2_sq <= '0;
      r_s2_x  <= '0;
      r_s2_y  <= '0;
      r_s2_fr <= 1'b0;
      r_s2_fc <= 1'b0;
    end else begin
      r_s2_v  <= r_s1_v;
      r_s2_sq <= r_s1_sq;
      r_s2_x  <= r_s1_x;
      r_s2_y  <= r_s1_y;
      r_s2_fr <= r_s1_fr;
      r_s2_fc <= r_s1_fc;
    end
  end

  assign w_rowsum = (r_s2_fc ? '0 : r_rowsum) + r_s2_sq;
  assign w_wdata  = w_rowsum + (r_s2_fr ? '0 : w_lb_rd);

  // running sum of squares along the current row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rowsum <= '0;
    else if (r_s2_v) r_rowsum <= w_rowsum;
  end

  sq_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .AW    (LB_AW),
    .DW    (WORD_SIZE)
  ) u_lb (
    .clk     (clk),
    .i_we    (r_s2_v),
    .i_waddr (r_s2_x[LB_AW-1:0]),
    .i_wdata (w_wdata),
    .i_re    (r_s1_v),
    .i_raddr (r_s1_x[LB_AW-1:0]),
    .o_rdata (w_lb_rd)
  );

  // cache write port: pipeline result or border zero
  always_comb begin
    we     = w_clr_we | r_s2_v;
    waddrX = '0;
    waddrY = '0;
    wdata  = '0;
    if (r_s2_v) begin
      waddrX = r_s2_x + ROW_WIDTH'(1);
      waddrY = r_s2_y + COL_WIDTH'(1);
      wdata  = w_wdata;
    end else if (r_state == CLR_ROW) begin
      waddrX = ROW_WIDTH'(r_cnt);
    end else if (r_state == CLR_COL) begin
      waddrY = COL_WIDTH'(r_cnt);
    end
  end

endmodule

// File: tb/tb_sq_integral_generator.sv
// Directed bench for sq_integral_generator at W=4, H=3.
// Each task drives one scenario and checks it inline.
module tb_sq_integral_generator;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  waddrX;
  logic [1:0]  waddrY;
  logic [31:0] wdata;
  logic        we;
  logic        busy;
  logic        frame_done;

  sq_integral_generator #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (3),
    .PIX_BITS   (8),
    .WORD_SIZE  (32),
    .ROW_WIDTH  (3),
    .COL_WIDTH  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .waddrX     (waddrX),
    .waddrY     (waddrY),
    .wdata      (wdata),
    .we         (we),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          wr_x [64];
  int          wr_y [64];
  int          wr_cyc [64];
  logic [31:0] wr_d [64];
  int          acc_cyc [64];
  int          nwr;
  int          nacc;
  int          done_cyc;
  bit          ready_clear;
  bit          post_busy;
  bit          post_done;
  bit          pre_abort;

  function automatic int pix_of(int mode, int x, int y);
    if (mode == 0) return 1;
    if (mode == 1) return 255;
    return x + 4 * y;
  endfunction

  function automatic int exp_ii(int mode, int xx, int yy);
    int s = 0;
    for (int i = 0; i < xx; i++)
      for (int j = 0; j < yy; j++)
        s += pix_of(mode, i, j) * pix_of(mode, i, j);
    return s;
  endfunction

  task automatic run_frame(input int mode, input bit gaps,
                           input bit poke, input int abort_after);
    int bx = 0;
    int by = 0;
    nwr = 0;
    nacc = 0;
    done_cyc = -1;
    ready_clear = 0;
    pre_abort = 0;
    start = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 300; k++) begin
      start = poke && (nacc == 5);
      pix_valid = (nacc < W * H) &&
                  (!gaps || ($urandom_range(0, 3) != 0));
      pix_in = 8'(pix_of(mode, bx, by));
      @(negedge clk);
      if (pix_ready && nwr < 8) ready_clear = 1;
      if (we && nwr < 64) begin
        wr_x[nwr] = int'(waddrX);
        wr_y[nwr] = int'(waddrY);
        wr_d[nwr] = wdata;
        wr_cyc[nwr] = cyc;
        nwr++;
      end
      if (pix_valid && pix_ready) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        bx++;
        if (bx == W) begin
          bx = 0;
          by++;
        end
      end
      if (frame_done) done_cyc = cyc;
      if (abort_after > 0 && nacc == abort_after) begin
        @(posedge clk);
        #3;
        pre_abort = busy && we && pix_ready;
        pix_valid = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    post_busy = busy;
    post_done = frame_done;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({we, busy, pix_ready, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {we, busy, pix_ready, frame_done});
    end
    checks++;
    if (wdata !== 32'd0 || waddrX !== 3'd0 || waddrY !== 2'd0) begin
      errors++;
      $display("FAIL reset_addr: got x=%0d y=%0d d=%0d expected 0",
               waddrX, waddrY, wdata);
    end
  endtask

  task automatic test_border();
    int ex, ey;
    run_frame(0, 0, 0, 0);
    checks++;
    if (ready_clear) begin
      errors++;
      $display("FAIL clr_ready: got pix_ready=1 expected 0");
    end
    for (int i = 0; i < 8; i++) begin
      ex = (i < 5) ? i : 0;
      ey = (i < 5) ? 0 : i - 4;
      checks++;
      if (wr_x[i] != ex || wr_y[i] != ey || wr_d[i] !== 32'd0 ||
          wr_cyc[i] != wr_cyc[0] + i) begin
        errors++;
        $display("FAIL clr_wr%0d: got (%0d,%0d)=%0d c%0d expected (%0d,%0d)=0 c%0d",
                 i, wr_x[i], wr_y[i], wr_d[i], wr_cyc[i], ex, ey,
                 wr_cyc[0] + i);
      end
    end
  endtask

  task automatic test_ones();
    int ex, ey;
    run_frame(0, 0, 0, 0);
    checks++;
    if (nwr != 20 || nacc != 12) begin
      errors++;
      $display("FAIL ones_count: got wr=%0d acc=%0d expected 20 12",
               nwr, nacc);
    end
    for (int i = 0; i < 12; i++) begin
      ex = i % W + 1;
      ey = i / W + 1;
      checks++;
      if (wr_x[8+i] != ex || wr_y[8+i] != ey ||
          wr_d[8+i] !== 32'(ex * ey)) begin
        errors++;
        $display("FAIL ones_wr%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                 i, wr_x[8+i], wr_y[8+i], wr_d[8+i], ex, ey, ex * ey);
      end
    end
    checks++;
    if (wr_x[19] != 4 || wr_y[19] != 3 || wr_d[19] !== 32'd12) begin
      errors++;
      $display("FAIL ones_final: got (%0d,%0d)=%0d expected (4,3)=12",
               wr_x[19], wr_y[19], wr_d[19]);
    end
    checks++;
    if (wr_cyc[19] != acc_cyc[11] + 2) begin
      errors++;
      $display("FAIL ones_latency: got %0d expected %0d",
               wr_cyc[19] - acc_cyc[11], 2);
    end
    checks++;
    if (done_cyc != wr_cyc[19] + 1) begin
      errors++;
      $display("FAIL ones_done: got cycle %0d expected %0d",
               done_cyc, wr_cyc[19] + 1);
    end
    checks++;
    if (post_busy || post_done) begin
      errors++;
      $display("FAIL ones_idle: got busy=%0b done=%0b expected 0 0",
               post_busy, post_done);
    end
  endtask

  task automatic test_max();
    logic [31:0] d11, d43;
    d11 = 32'hFFFF_FFFF;
    d43 = 32'hFFFF_FFFF;
    run_frame(1, 0, 0, 0);
    for (int i = 8; i < nwr; i++) begin
      if (wr_x[i] == 1 && wr_y[i] == 1) d11 = wr_d[i];
      if (wr_x[i] == 4 && wr_y[i] == 3) d43 = wr_d[i];
    end
    checks++;
    if (d11 !== 32'd65025) begin
      errors++;
      $display("FAIL max_11: got %0d expected 65025", d11);
    end
    checks++;
    if (d43 !== 32'd780300) begin
      errors++;
      $display("FAIL max_43: got %0d expected 780300", d43);
    end
  endtask

  task automatic test_ramp_gaps();
    int ex, ey;
    run_frame(2, 1, 0, 0);
    checks++;
    if (nwr != 20 || nacc != 12 || done_cyc < 0) begin
      errors++;
      $display("FAIL ramp_count: got wr=%0d acc=%0d done=%0d expected 20 12 >=0",
               nwr, nacc, done_cyc);
    end
    for (int i = 0; i < 12; i++) begin
      ex = i % W + 1;
      ey = i / W + 1;
      checks++;
      if (wr_x[8+i] != ex || wr_y[8+i] != ey ||
          wr_d[8+i] !== 32'(exp_ii(2, ex, ey)) ||
          wr_cyc[8+i] != acc_cyc[i] + 2) begin
        errors++;
        $display("FAIL ramp_wr%0d: got (%0d,%0d)=%0d c%0d expected (%0d,%0d)=%0d c%0d",
                 i, wr_x[8+i], wr_y[8+i], wr_d[8+i], wr_cyc[8+i],
                 ex, ey, exp_ii(2, ex, ey), acc_cyc[i] + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ex, ey;
    for (int f = 0; f < 2; f++) begin
      run_frame(2, 0, f == 0, 0);
      checks++;
      if (nwr != 20 || done_cyc < 0) begin
        errors++;
        $display("FAIL b2b_count%0d: got wr=%0d done=%0d expected 20 >=0",
                 f, nwr, done_cyc);
      end
      for (int i = 0; i < 12; i++) begin
        ex = i % W + 1;
        ey = i / W + 1;
        checks++;
        if (wr_x[8+i] != ex || wr_y[8+i] != ey ||
            wr_d[8+i] !== 32'(exp_ii(2, ex, ey))) begin
          errors++;
          $display("FAIL b2b%0d_wr%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   f, i, wr_x[8+i], wr_y[8+i], wr_d[8+i],
                   ex, ey, exp_ii(2, ex, ey));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ex, ey;
    run_frame(1, 0, 0, 6);
    checks++;
    if (!pre_abort) begin
      errors++;
      $display("FAIL abort_pre: got busy&we&ready=0 expected 1");
    end
    #1;
    checks++;
    if ({we, busy, pix_ready, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_async: got %b expected 0000",
               {we, busy, pix_ready, frame_done});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(0, 0, 0, 0);
    checks++;
    if (nwr != 20 || done_cyc < 0) begin
      errors++;
      $display("FAIL abort_count: got wr=%0d done=%0d expected 20 >=0",
               nwr, done_cyc);
    end
    for (int i = 0; i < 12; i++) begin
      ex = i % W + 1;
      ey = i / W + 1;
      checks++;
      if (wr_x[8+i] != ex || wr_y[8+i] != ey ||
          wr_d[8+i] !== 32'(ex * ey)) begin
        errors++;
        $display("FAIL abort_wr%0d: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                 i, wr_x[8+i], wr_y[8+i], wr_d[8+i], ex, ey, ex * ey);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    pix_in = 8'd0;
    pix_valid = 1'b0;
    #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_border();
    test_ones();
    test_max();
    test_ramp_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
